sram_like_arbiter: RTL

Parametrised N-master to 1-slave arbiter for the core's SRAM-like request/addr_ok/data_ok protocol. Generalises the fixed inst/data split so that several masters can share one memory-side port: IF, MEM, and later a TLB walker or cache refill. It sits between the pipeline stages and the bridge. Requests are merged under fixed-priority or round-robin arbitration, and in-order responses are routed back through a channel-ID order FIFO.

---
 rtl/sram_like_arbiter_pkg.sv | 20 ++
 rtl/sram_like_order_fifo.sv | 51 +++++
 rtl/sram_like_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings and elaboration helpers for the SRAM-like N:1 request arbiter.
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

endpackage

// File: rtl/sram_like_order_fifo.sv
// In-order channel-ID FIFO: records which master owns each accepted request so
// responses can be routed back in slave order.
module sram_like_order_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter  int W     = 1,
  parameter  int DEPTH = 4,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage needs no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-master to 1-slave arbiter for the SRAM-like req/addr_ok/data_ok protocol,
// with request locking until acceptance and in-order response routing.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter  int N_CH     = 2,
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int MAX_OUT  = 4,
  parameter  int ARB_MODE = ARB_FIXED,
  localparam int CH_W     = (N_CH > 1) ? clog2(N_CH) : 1,
  localparam int STRB_W   = DATA_W / 8,
  localparam int CNT_W    = clog2(MAX_OUT) + 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_CH-1:0]          m_req,
  input  logic [N_CH-1:0]          m_wr,
  input  logic [2*N_CH-1:0]        m_size,
  input  logic [N_CH*STRB_W-1:0]   m_wstrb,
  input  logic [N_CH*ADDR_W-1:0]   m_addr,
  input  logic [N_CH*DATA_W-1:0]   m_wdata,
  output logic [N_CH-1:0]          m_addr_ok,
  output logic [N_CH-1:0]          m_data_ok,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     s_req,
  output logic                     s_wr,
  output logic [1:0]               s_size,
  output logic [STRB_W-1:0]        s_wstrb,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  input  logic                     s_addr_ok,
  input  logic                     s_data_ok,
  input  logic [DATA_W-1:0]        s_rdata,
  output logic [CNT_W-1:0]         outstanding,
  output logic                     err_unexp
);

  logic              r_lock_valid;
  logic [CH_W-1:0]   r_lock_ch;
  logic [CH_W-1:0]   r_rr_ptr;
  logic              r_err_unexp;

  logic              w_any;
  logic [CH_W-1:0]   w_grant;
  logic              w_accept;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CH_W-1:0]   w_head;

  logic [ADDR_W-1:0] w_addr_ch  [N_CH];
  logic [DATA_W-1:0] w_wdata_ch [N_CH];
  logic [STRB_W-1:0] w_wstrb_ch [N_CH];
  logic [1:0]        w_size_ch  [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    assign w_addr_ch[i]  = m_addr[i*ADDR_W +: ADDR_W];
    assign w_wdata_ch[i] = m_wdata[i*DATA_W +: DATA_W];
    assign w_wstrb_ch[i] = m_wstrb[i*STRB_W +: STRB_W];
    assign w_size_ch[i]  = m_size[2*i +: 2];
    assign m_addr_ok[i]  = w_accept && (w_grant == CH_W'(i));
    assign m_data_ok[i]  = w_pop && (w_head == CH_W'(i));
  end

  // Scan from lowest to highest priority so the last requester found wins.
  always_comb begin
    logic [CH_W-1:0] idx;
    w_any   = r_lock_valid;
    w_grant = r_lock_ch;
    idx     = '0;
    if (!r_lock_valid) begin
      for (int k = N_CH; k >= 1; k--) begin
        idx = (ARB_MODE == ARB_RR) ? CH_W'((int'(r_rr_ptr) + k) % N_CH) : CH_W'(k - 1);
        if (m_req[idx]) begin
          w_any   = 1'b1;
          w_grant = idx;
        end
      end
    end
  end

  // Full blocks new requests even on a popping cycle, keeping s_req off the pop path.
  assign s_req     = w_any && !w_fifo_full;
  assign w_accept  = s_req && s_addr_ok;
  assign w_pop     = s_data_ok && !w_fifo_empty;
  assign m_rdata   = s_rdata;
  assign err_unexp = r_err_unexp;

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    s_wr    = 1'b0;
    s_size  = '0;
    s_wstrb = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (s_req) begin
      s_wr    = m_wr[w_grant];
      s_size  = w_size_ch[w_grant];
      s_wstrb = w_wstrb_ch[w_grant];
      s_addr  = w_addr_ch[w_grant];
      s_wdata = w_wdata_ch[w_grant];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lock_valid <= 1'b0;
      r_lock_ch    <= '0;
      r_rr_ptr     <= CH_W'(N_CH - 1);
      r_err_unexp  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_lock_valid <= 1'b0;
      end else if (s_req) begin
        r_lock_valid <= 1'b1;
        r_lock_ch    <= w_grant;
      end
      if (w_accept && (ARB_MODE == ARB_RR)) r_rr_ptr <= w_grant;
      if (s_data_ok && w_fifo_empty) r_err_unexp <= 1'b1;
    end
  end

  sram_like_order_fifo #(
    .W     (CH_W),
    .DEPTH (MAX_OUT)
  ) u_order_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_din   (w_grant),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (outstanding)
  );

endmodule
